// File: rtl/free_list_pkg.sv
// free_list_pkg: shared processor constants for the rename free list and
// the ALU operand-select encodings used elsewhere in the core.
package free_list_pkg;

    localparam int FL_SIZE_DEF = 96;
    localparam int PR_W_DEF    = 7;
    localparam int RESET_BASE  = 32;
    localparam int CNT_W       = 7;

    localparam logic [1:0] ALU_OPA_IS_REGA = 2'd0;
    localparam logic [1:0] ALU_OPA_IS_NPC  = 2'd1;
    localparam logic [1:0] ALU_OPA_IS_PC   = 2'd2;
    localparam logic [1:0] ALU_OPA_IS_ZERO = 2'd3;

    localparam logic [1:0] ALU_OPB_IS_REGB = 2'd0;
    localparam logic [1:0] ALU_OPB_IS_IMM  = 2'd1;
    localparam logic [1:0] ALU_OPB_IS_BR   = 2'd2;
    localparam logic [1:0] ALU_OPB_IS_JMP  = 2'd3;

endpackage

// File: rtl/free_list.sv
// free_list: circular physical-register free list, two pops/pushes per cycle.
// Optional FL_BYPASS_EN forwards same-cycle retire tags when fewer than two are stored.
`default_nettype none

module free_list
    import free_list_pkg::*;
#(
    parameter int FL_SIZE = FL_SIZE_DEF,
    parameter int PR_W    = PR_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       id_dispatch_num,
    input  logic [1:0]       rob_retire_num,
    input  logic [PR_W-1:0]  rob_retire_told0,
    input  logic [PR_W-1:0]  rob_retire_told1,
    input  logic             recover,
    output logic [PR_W-1:0]  fl_pr0,
    output logic [PR_W-1:0]  fl_pr1,
    output logic [1:0]       fl_free_num,
    output logic [CNT_W-1:0] fl_count,
    output logic             fl_err
);

    localparam int PTR_W = $clog2(FL_SIZE);
    localparam int SUM_W = CNT_W + 2;
    localparam logic [SUM_W-1:0] c_size = SUM_W'(FL_SIZE);

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [1:0] n);
        logic [PTR_W:0] s;
        s = {1'b0, p} + {{(PTR_W-1){1'b0}}, n};
        if (s >= (PTR_W+1)'(FL_SIZE)) begin
            s = s - (PTR_W+1)'(FL_SIZE);
        end
        return s[PTR_W-1:0];
    endfunction

    logic [PR_W-1:0]  r_entry [FL_SIZE];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_err;

    logic [1:0]       w_ret_req;
    logic [SUM_W-1:0] w_count_x;
    logic [SUM_W-1:0] w_avail;
    logic [1:0]       w_free_num;
    logic [PTR_W-1:0] w_head1;
    logic [1:0]       w_pop;
    logic [1:0]       w_push;
    logic [SUM_W-1:0] w_room;
    logic             w_under;
    logic             w_over;
    logic [PTR_W-1:0] w_tail1;
    logic [PTR_W-1:0] w_tail_nxt;
    logic [PTR_W-1:0] w_head_adv;

    assign w_ret_req = (rob_retire_num == 2'd3) ? 2'd2 : rob_retire_num;
    assign w_count_x = {2'b00, r_count};
    assign w_head1   = ptr_add(r_head, 2'd1);

`ifdef FL_BYPASS_EN
    assign w_avail = (r_count < CNT_W'(2)) ? w_count_x + {{(SUM_W-2){1'b0}}, w_ret_req} : w_count_x;
    assign fl_pr0  = (r_count != '0) ? r_entry[r_head] : rob_retire_told0;
    assign fl_pr1  = (r_count >= CNT_W'(2)) ? r_entry[w_head1] :
                     (r_count == CNT_W'(1)) ? rob_retire_told0 : rob_retire_told1;
`else
    assign w_avail = w_count_x;
    assign fl_pr0  = r_entry[r_head];
    assign fl_pr1  = r_entry[w_head1];
`endif

    assign w_free_num = (w_avail >= SUM_W'(2)) ? 2'd2 : w_avail[1:0];

    // Dispatch is ignored during recovery; retire pushes still land.
    assign w_under = !recover && (id_dispatch_num > w_free_num);
    assign w_pop   = recover ? 2'd0 : (w_under ? w_free_num : id_dispatch_num);

    assign w_room = c_size - w_count_x + {{(SUM_W-2){1'b0}}, w_pop};
    assign w_push = ({{(SUM_W-2){1'b0}}, w_ret_req} > w_room) ? w_room[1:0] : w_ret_req;
    assign w_over = (w_count_x + {{(SUM_W-2){1'b0}}, rob_retire_num}) >
                    (c_size + {{(SUM_W-2){1'b0}}, w_pop});

    assign w_tail1    = ptr_add(r_tail, 2'd1);
    assign w_tail_nxt = ptr_add(r_tail, w_push);
    assign w_head_adv = ptr_add(r_head, w_pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FL_SIZE; i++) begin
                r_entry[i] <= PR_W'(RESET_BASE + i);
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= CNT_W'(FL_SIZE);
            r_err   <= 1'b0;
        end else begin
            if (w_push != 2'd0) begin
                r_entry[r_tail] <= rob_retire_told0;
            end
            if (w_push == 2'd2) begin
                r_entry[w_tail1] <= rob_retire_told1;
            end
            r_tail <= w_tail_nxt;
            if (recover) begin
                r_head  <= w_tail_nxt;
                r_count <= CNT_W'(FL_SIZE);
            end else begin
                r_head  <= w_head_adv;
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
            r_err <= w_under | w_over;
        end
    end

    assign fl_free_num = w_free_num;
    assign fl_count    = r_count;
    assign fl_err      = r_err;

endmodule

`default_nettype wire

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
- REQ-001 The block SHALL have parameter FL_SIZE, default 96: number of free-list slots (physical registers minus the 32 architectural registers).
- REQ-002 The block SHALL have parameter PR_W, default 7: physical-register tag width.
- REQ-003 The block SHALL have port clock, input, width 1: the single clock; all state updates on its rising edge.
- REQ-004 The block SHALL have port reset, input, width 1: asynchronous, active-low reset (asserted at 0).
- REQ-005 The block SHALL have port id_dispatch_num, input, width 2: number of tags consumed by dispatch this cycle (0-2).
- REQ-006 The block SHALL have port rob_retire_num, input, width 2: number of Told tags freed by retirement this cycle (0-2).
- REQ-007 The block SHALL have ports rob_retire_told0 and rob_retire_told1, input, width PR_W each: freed tags; told0 is valid when rob_retire_num>=1, told1 when rob_retire_num==2.
- REQ-008 The block SHALL have port recover, input, width 1: branch-mispredict/exception recovery.
- REQ-009 The block SHALL have ports fl_pr0 and fl_pr1, output, width PR_W each: the next two free tags, oldest first.
- REQ-010 The block SHALL have port fl_free_num, output, width 2: tags available this cycle, equal to min(available, 2).
- REQ-011 The block SHALL have port fl_count, output, width 7: registered occupancy (0..FL_SIZE).
- REQ-012 The block SHALL have port fl_err, output, width 1: registered one-cycle pulse flagging an underflow or overflow attempt.

Function
- REQ-013 Storage SHALL be a circular buffer of FL_SIZE entries with a head (read) pointer, a tail (write) pointer and a count; both pointers SHALL wrap from FL_SIZE-1 to 0.
- REQ-014 fl_pr0 SHALL equal entry[head] and fl_pr1 SHALL equal entry[(head+1) mod FL_SIZE], combinationally from registered state.
- REQ-015 On a rising edge without recover, retire SHALL write told0 at tail and told1 at tail+1 (mod FL_SIZE), and tail SHALL advance by the number of pushes performed.
- REQ-016 Pops SHALL equal min(id_dispatch_num, fl_free_num); head SHALL advance by the pops performed.
- REQ-017 The next count SHALL be count + pushes - pops.
- REQ-018 If id_dispatch_num > fl_free_num, the excess pops SHALL be dropped and fl_err SHALL be 1 in the next cycle.
- REQ-019 If count + rob_retire_num - pops > FL_SIZE, the excess pushes SHALL be dropped (told1 first) and fl_err SHALL be 1 in the next cycle.
- REQ-020 With recover=1, retirement pushes SHALL still be applied; head SHALL be set to the post-push tail, count SHALL be set to FL_SIZE, and id_dispatch_num SHALL be ignored.
- REQ-021 A simultaneous push and pop on the same slot with count==0 SHALL be consistent: the written tag is consumed and the slot is freed.
- REQ-022 Latency: a freed tag SHALL be visible on fl_pr* one cycle after retirement, unless FL_BYPASS_EN is defined.

Reset
- REQ-023 While reset==0, entry[i] SHALL be 32+i for i=0..FL_SIZE-1.
- REQ-024 While reset==0, head SHALL be 0, tail SHALL be 0 and count SHALL be FL_SIZE.
- REQ-025 While reset==0, fl_err SHALL be 0, giving outputs fl_pr0=32, fl_pr1=33, fl_free_num=2 and fl_count=96.
- REQ-026 Assertion of reset mid-operation SHALL take effect immediately, without waiting for a clock edge.

Configuration
- REQ-027 When FL_BYPASS_EN is defined, with count<2, fl_free_num SHALL include this cycle's valid retire tags, and fl_pr0/fl_pr1 SHALL be filled from stored entries first, then from told0, then from told1.
- REQ-028 When FL_BYPASS_EN is undefined, fl_free_num SHALL be min(count, 2) and no path SHALL exist from the rob_retire_* inputs to the outputs.

Structure
- REQ-029 FL_SIZE, PR_W and the reset base tag (32) SHALL reside in the shared processor package and header, alongside the ALU operand-select defines.
- REQ-030 The block SHALL be a single module with no sub-module; the pointer increment-with-wrap logic SHALL be a local function.

Verification
- REQ-031 Release reset with idle inputs -> fl_pr0=32, fl_pr1=33, fl_free_num=2, fl_count=96.
- REQ-032 id_dispatch_num=2 for one cycle -> next cycle fl_pr0=34, fl_pr1=35, fl_count=94.
- REQ-033 Dispatch 2 for 48 cycles, then id_dispatch_num=2 once more -> fl_free_num=0, fl_count=0, head does not move, fl_err=1 for one cycle.
- REQ-034 At count=0, retire 2 with told0=5 and told1=7 -> next cycle fl_pr0=5, fl_pr1=7, fl_count=2; with FL_BYPASS_EN, the same cycle shows fl_pr0=5, fl_pr1=7, fl_free_num=2.
- REQ-035 From reset, dispatch 2+2 (tags 32..35), then recover with retire 0 -> next cycle fl_pr0=32, fl_count=96.
- REQ-036 Drive reset=0 asynchronously between edges during a dispatch burst -> outputs return to the reset values before the next edge.
